fns_dec_pipe: RTL and testbench
===============================

Name: fns_dec_pipe

Overview:
- Parametrised, pipelined successor to the fixed 7-bit Fibonacci-numeral-system (FNS) CAC decoder.
- Decodes a CW-bit crosstalk-avoidance codeword into DW-bit data: sums per-bit weights over the bits set in codeword AND enable mask.
- Weights are held in a writable register table (reset to the Fibonacci sequence), so local-AFNS weight sets can be reloaded at runtime.
- Sits on the receive side of a bus link; valid/ready handshake on input and output; sustains 1 word/cycle.

Parameters:
- CW, 7, codeword width in bits (>=2).
- DW, 5, decoded data width in bits.
- WW, DW, weight width in bits.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  decoder can accept a word this cycle.
- in_code  in  CW  codeword; bit i carries weight w[i].
- in_en  in  CW  per-bit enable mask; 0 forces that bit's contribution to 0.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  DW  decoded value.
- out_ovf  out  1  sum exceeded DW bits (see Optional Feature).
- wt_we  in  1  weight-table write strobe.
- wt_addr  in  clog2(CW)  weight index.
- wt_data  in  WW  new weight value.

Behaviour:
- Reset: synchronous, active-high. Clears both stage valids (out_valid=0, in_ready=1), out_data=0, out_ovf=0, and loads weights w[0]=1, w[1]=1, w[i]=w[i-1]+w[i-2], truncated to WW bits. Reset mid-operation discards all in-flight words; a write in the reset cycle is ignored.
- Transfers: an input transfer occurs when in_valid&in_ready; an output transfer when out_valid&out_ready.
- Stage 1 (on input transfer): registers term[i] = (in_code[i]&in_en[i]) ? w[i] : 0 for all i; sets s1_valid.
- Stage 2: registers out_data = sum of terms modulo 2^DW; the internal sum is computed at DW+clog2(CW) bits.
- Latency: exactly 2 cycles from input transfer to out_valid when unstalled.
- Stall: stage 2 advances when !out_valid | out_ready. Stage 1 advances when stage 2 advances or !s1_valid.
- in_ready = !s1_valid | stage-2-advance (combinational). A full pipeline holds data stable while out_ready=0. No word is dropped or duplicated.
- Weight writes: a write at cycle t updates w[wt_addr] at the t edge. A word accepted in the same cycle uses the old weight; words accepted from t+1 use the new one. In-flight words are never affected. wt_addr>=CW is ignored.
- Simultaneous input and output transfers on a full pipeline give full throughput.
- Mask all-zero yields out_data=0.

Optional Feature:
- Macro FNS_DEC_OVF_CHK_EN.
- Defined: out_ovf is registered alongside out_data and is 1 iff the full-width sum >= 2^DW. out_data is still the truncated value.
- Undefined: no wide-sum compare logic; out_ovf tied to 0.

Decomposition:
- Shared package fns_pkg holds:
  - clog2 function;
  - fib(i, width) function used for reset weights;
  - default CW/DW constants for the 5-to-7 code.
- One natural sub-module, fns_wt_regfile: CW x WW weight registers with Fibonacci reset, one write port and all weights exposed in parallel.
- Pipeline and handshake logic stay in the top module.

Test Plan:
- After reset, in_code=7'b1010101, in_en=7'h7F, out_ready=1 -> 2 cycles later out_data=21 (1+2+5+13), out_ovf=0.
- Mask test: in_code=7'h7F, in_en=7'b0001111 -> out_data=7 (1+1+2+3).
- Back-to-back: 8 consecutive words with out_ready=1 -> 8 outputs on consecutive cycles, in order. Then hold out_ready=0 for 3 cycles -> in_ready drops after 2 accepted words, out_data stable, no loss.
- Weight write: wt_we=1, wt_addr=6, wt_data=20, with in_code=7'b1000000 accepted the same cycle -> 13. Same code the next cycle -> 20. Write to wt_addr=7 -> no change.
- Overflow: in_code=7'h7F, in_en=7'h7F -> out_data=1 (33 mod 32); out_ovf=1 with FNS_DEC_OVF_CHK_EN, 0 without.
- Reset mid-flight: assert rst with 2 words in flight -> next cycle out_valid=0, in_ready=1, weights back to 1,1,2,3,5,8,13.

Source files
------------

// File: rtl/fns_pkg.sv
// Shared helpers and default sizes for the Fibonacci-numeral-system (FNS) CAC decoder.
package fns_pkg;

  localparam int DEF_CW = 7;
  localparam int DEF_DW = 5;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Fibonacci term i (w0 = w1 = 1), wrapped to 'width' bits at every step.
  function automatic longint unsigned fib(input int i, input int width);
    longint unsigned a, b, t, mask;
    mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    a = 64'd1;
    b = 64'd1;
    for (int k = 2; k <= i; k++) begin
      t = (a + b) & mask;
      a = b;
      b = t;
    end
    return b & mask;
  endfunction

endpackage

// File: rtl/fns_wt_regfile.sv
// CW x WW weight table: Fibonacci values on reset, one write port, all weights read in parallel.
module fns_wt_regfile
  import fns_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int WW = DEF_DW,
  parameter int AW = clog2(CW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   we,
  input  logic [AW-1:0]          addr,
  input  logic [WW-1:0]          wdata,
  output logic [CW-1:0][WW-1:0]  wt
);

  logic [CW-1:0][WW-1:0] wt_d, wt_q;

  // Addresses past the last weight are silently dropped.
  always_comb begin
    wt_d = wt_q;
    if (we && (32'(addr) < CW)) wt_d[addr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CW; i++) wt_q[i] <= WW'(fib(i, WW));
    end else begin
      wt_q <= wt_d;
    end
  end

  assign wt = wt_q;

endmodule

// File: rtl/fns_dec_pipe.sv
// Two-stage FNS CAC decoder with valid/ready handshake and a reloadable weight table.
// Define FNS_DEC_OVF_CHK_EN to register out_ovf (full sum >= 2^DW); otherwise out_ovf is 0.
module fns_dec_pipe
  import fns_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int DW = DEF_DW,
  parameter int WW = DW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CW-1:0]         in_code,
  input  logic [CW-1:0]         in_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  out_ovf,
  input  logic                  wt_we,
  input  logic [clog2(CW)-1:0]  wt_addr,
  input  logic [WW-1:0]         wt_data
);

  localparam int AW = clog2(CW);
`ifdef FNS_DEC_OVF_CHK_EN
  localparam int SW = DW + clog2(CW);
`else
  // Only the low DW bits are ever observed, so the sum need not be wider.
  localparam int SW = DW;
`endif

  logic [CW-1:0][WW-1:0] wt;

  fns_wt_regfile #(.CW(CW), .WW(WW), .AW(AW)) u_wt (
    .clk   (clk),
    .rst   (rst),
    .we    (wt_we),
    .addr  (wt_addr),
    .wdata (wt_data),
    .wt    (wt)
  );

  logic                  adv_p2, in_xfer;
  logic                  vld_p1_d, vld_p1_q, vld_p2_d, vld_p2_q;
  logic [CW-1:0][WW-1:0] term_p1_d, term_p1_q;
  logic [SW-1:0]         sum_p1;
  logic [DW-1:0]         data_p2_d, data_p2_q;

  always_comb begin
    adv_p2   = !vld_p2_q || out_ready;
    in_ready = !vld_p1_q || adv_p2;
    in_xfer  = in_valid && in_ready;

    // Stage 1: gate each weight by codeword bit and enable mask
    vld_p1_d  = vld_p1_q;
    term_p1_d = term_p1_q;
    if (in_ready) begin
      vld_p1_d = in_xfer;
      if (in_xfer) begin
        for (int i = 0; i < CW; i++)
          term_p1_d[i] = (in_code[i] && in_en[i]) ? wt[i] : '0;
      end
    end

    sum_p1 = '0;
    for (int i = 0; i < CW; i++) sum_p1 = sum_p1 + SW'(term_p1_q[i]);

    // Stage 2: registered sum, truncated to DW bits
    vld_p2_d  = vld_p2_q;
    data_p2_d = data_p2_q;
    if (adv_p2) begin
      vld_p2_d = vld_p1_q;
      if (vld_p1_q) data_p2_d = sum_p1[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    term_p1_q <= term_p1_d;
    if (rst) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      data_p2_q <= data_p2_d;
    end
  end

`ifdef FNS_DEC_OVF_CHK_EN
  logic ovf_p2_d, ovf_p2_q;

  always_comb begin
    ovf_p2_d = ovf_p2_q;
    if (adv_p2 && vld_p1_q) ovf_p2_d = |sum_p1[SW-1:DW];
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_p2_q <= 1'b0;
    else     ovf_p2_q <= ovf_p2_d;
  end

  assign out_ovf = ovf_p2_q;
`else
  assign out_ovf = 1'b0;
`endif

  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;

endmodule

// File: tb/tb_fns_dec_pipe.sv
// Directed self-checking bench for fns_dec_pipe (default CW=7, DW=5).
module tb_fns_dec_pipe;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [6:0] in_code = '0;
  logic [6:0] in_en = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [4:0] out_data;
  logic       out_ovf;
  logic       wt_we = 1'b0;
  logic [2:0] wt_addr = '0;
  logic [4:0] wt_data = '0;

  int n_checks = 0;
  int n_pass = 0;

  fns_dec_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_code   (in_code),
    .in_en     (in_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .wt_we     (wt_we),
    .wt_addr   (wt_addr),
    .wt_data   (wt_data)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one word through an empty pipeline and return what appears two edges later.
  task automatic run_word(input logic [6:0] code, input logic [6:0] en,
                          output logic v, output logic [4:0] d, output logic o);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_code   = code;
    in_en     = en;
    tick();
    in_valid = 1'b0;
    tick();
    v = out_valid;
    d = out_data;
    o = out_ovf;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_data !== 5'd0) $display("FAIL reset_out_data: got %0d expected 0", out_data); else n_pass++;
    n_checks++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b expected 0", out_ovf); else n_pass++;
  endtask

  task automatic test_basic();
    logic v, o;
    logic [4:0] d;
    run_word(7'b1010101, 7'h7F, v, d, o);
    n_checks++; if (v !== 1'b1) $display("FAIL basic_valid: got %b expected 1", v); else n_pass++;
    n_checks++; if (d !== 5'd21) $display("FAIL basic_data: got %0d expected 21", d); else n_pass++;
    n_checks++; if (o !== 1'b0) $display("FAIL basic_ovf: got %b expected 0", o); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL basic_drain: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_mask();
    logic v, o;
    logic [4:0] d;
    run_word(7'h7F, 7'b0001111, v, d, o);
    n_checks++; if (d !== 5'd7) $display("FAIL mask_data: got %0d expected 7", d); else n_pass++;
    run_word(7'h7F, 7'h00, v, d, o);
    n_checks++; if (v !== 1'b1 || d !== 5'd0) $display("FAIL mask_zero: got v=%b d=%0d expected v=1 d=0", v, d); else n_pass++;
    run_word(7'b0110000, 7'b1011111, v, d, o);
    n_checks++; if (d !== 5'd5) $display("FAIL mask_mixed: got %0d expected 5", d); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [6:0] codes [8];
    logic [4:0] exp_d [8];
    codes = '{7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8};
    exp_d = '{5'd1, 5'd1, 5'd2, 5'd2, 5'd3, 5'd3, 5'd4, 5'd3};
    out_ready = 1'b1;
    in_en     = 7'h7F;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) begin
        in_valid = 1'b1;
        in_code  = codes[i];
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i >= 1) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== exp_d[i-1])
          $display("FAIL b2b_word%0d: got v=%b d=%0d expected v=1 d=%0d", i - 1, out_valid, out_data, exp_d[i-1]);
        else n_pass++;
      end
    end
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drain: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    in_en     = 7'h7F;
    in_valid  = 1'b1;
    in_code   = 7'b0000001;
    tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_ready1: got %b expected 1", in_ready); else n_pass++;
    in_code = 7'b0010000;
    tick();
    in_code = 7'b0100000;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready2: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 5'd1) $display("FAIL stall_head: got v=%b d=%0d expected v=1 d=1", out_valid, out_data); else n_pass++;
    tick();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL stall_ready3: got %b expected 0", in_ready); else n_pass++;
    n_checks++; if (out_data !== 5'd1) $display("FAIL stall_stable: got %0d expected 1", out_data); else n_pass++;
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL stall_release: got %b expected 1", in_ready); else n_pass++;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 5'd5) $display("FAIL stall_second: got v=%b d=%0d expected v=1 d=5", out_valid, out_data); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 5'd8) $display("FAIL stall_third: got v=%b d=%0d expected v=1 d=8", out_valid, out_data); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stall_drain: got %b expected 0", out_valid); else n_pass++;
  endtask

  task automatic test_overflow();
    logic v, o, exp_o;
    logic [4:0] d;
`ifdef FNS_DEC_OVF_CHK_EN
    exp_o = 1'b1;
`else
    exp_o = 1'b0;
`endif
    run_word(7'h7F, 7'h7F, v, d, o);
    n_checks++; if (d !== 5'd1) $display("FAIL ovf_data: got %0d expected 1", d); else n_pass++;
    n_checks++; if (o !== exp_o) $display("FAIL ovf_flag: got %b expected %b", o, exp_o); else n_pass++;
    run_word(7'b0111111, 7'h7F, v, d, o);
    n_checks++; if (d !== 5'd20 || o !== 1'b0) $display("FAIL ovf_clear: got d=%0d o=%b expected d=20 o=0", d, o); else n_pass++;
    tick();
  endtask

  task automatic test_weight_write();
    logic v, o;
    logic [4:0] d;
    out_ready = 1'b1;
    in_en     = 7'h7F;
    in_code   = 7'b1000000;
    in_valid  = 1'b1;
    wt_we     = 1'b1;
    wt_addr   = 3'd6;
    wt_data   = 5'd20;
    tick();
    wt_we = 1'b0;
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || out_data !== 5'd13) $display("FAIL wt_old: got v=%b d=%0d expected v=1 d=13", out_valid, out_data); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b1 || out_data !== 5'd20) $display("FAIL wt_new: got v=%b d=%0d expected v=1 d=20", out_valid, out_data); else n_pass++;
    tick();
    wt_we   = 1'b1;
    wt_addr = 3'd7;
    wt_data = 5'd3;
    tick();
    wt_we = 1'b0;
    run_word(7'b1000000, 7'h7F, v, d, o);
    n_checks++; if (d !== 5'd20) $display("FAIL wt_addr_oob: got %0d expected 20", d); else n_pass++;
    run_word(7'b0000001, 7'h7F, v, d, o);
    n_checks++; if (d !== 5'd1) $display("FAIL wt_addr_oob_w0: got %0d expected 1", d); else n_pass++;
    tick();
  endtask

  task automatic test_reset_midflight();
    logic v, o;
    logic [4:0] d;
    out_ready = 1'b0;
    in_en     = 7'h7F;
    in_valid  = 1'b1;
    in_code   = 7'b0000100;
    tick();
    in_code = 7'b0001000;
    tick();
    in_valid = 1'b0;
    rst      = 1'b1;
    wt_we    = 1'b1;
    wt_addr  = 3'd0;
    wt_data  = 5'd9;
    tick();
    rst   = 1'b0;
    wt_we = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %b expected 0", out_valid); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL midrst_in_ready: got %b expected 1", in_ready); else n_pass++;
    n_checks++; if (out_data !== 5'd0) $display("FAIL midrst_out_data: got %0d expected 0", out_data); else n_pass++;
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL midrst_no_ghost: got %b expected 0", out_valid); else n_pass++;
    run_word(7'b1000000, 7'h7F, v, d, o);
    n_checks++; if (d !== 5'd13) $display("FAIL midrst_w6: got %0d expected 13", d); else n_pass++;
    run_word(7'b0000001, 7'h7F, v, d, o);
    n_checks++; if (d !== 5'd1) $display("FAIL midrst_w0: got %0d expected 1", d); else n_pass++;
    run_word(7'h7F, 7'h7F, v, d, o);
    n_checks++; if (d !== 5'd1) $display("FAIL midrst_all: got %0d expected 1", d); else n_pass++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask();
    test_back_to_back();
    test_stall();
    test_overflow();
    test_weight_write();
    test_reset_midflight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
